// File: rtl/uart_irq_pkg.sv
// rtl/uart_irq_pkg.sv - register map, source indices and default sticky mask for uart_irq_ctrl
package uart_irq_pkg;

    typedef enum logic [1:0] {
        ADDR_STATUS  = 2'd0,
        ADDR_ENABLE  = 2'd1,
        ADDR_PENDING = 2'd2,
        ADDR_MISS    = 2'd3
    } reg_addr_e;

    localparam int FE   = 0;
    localparam int CRCE = 1;
    localparam int ORE  = 2;
    localparam int NF   = 3;
    localparam int TXI  = 4;
    localparam int TBNF = 5;
    localparam int DR   = 6;

    // Error sources latch until software clears them; flow-control sources stay live.
    localparam logic [6:0] STICKY_DEFAULT = 7'b000_1111;

    localparam logic [7:0] MISS_MAX = 8'hFF;

endpackage

// File: rtl/irq_sticky_cell.sv
// rtl/irq_sticky_cell.sv - one-bit rising-edge detector with set-wins W1C sticky flag
module irq_sticky_cell (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic clr,
    output logic flag,
    output logic miss
);

    logic src_q, src_d;
    logic flag_q, flag_d;
    logic rise;

    always_comb begin
        rise   = src & ~src_q;
        src_d  = src;
        flag_d = flag_q;
        if (clr) begin
            flag_d = 1'b0;
        end
        // A fresh event must never be lost to a racing software clear.
        if (rise) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;
    assign miss = rise & flag_q;

endmodule

// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - UART interrupt status/enable controller with miss counter and registered irq
module uart_irq_ctrl
    import uart_irq_pkg::*;
#(
    parameter int              NSRC   = 7,
    parameter int              DW     = 8,
    parameter logic [NSRC-1:0] STICKY = STICKY_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            wrien,
    input  logic            rden,
    input  logic [1:0]      addr,
    input  logic [DW-1:0]   idata,
    output logic [DW-1:0]   odata,
    output logic            irq
);

    logic [NSRC-1:0] status;
    logic [NSRC-1:0] miss_vec;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [7:0]      miss_q, miss_d;
    logic [DW-1:0]   odata_q, odata_d;
    logic            irq_q, irq_d;
    logic [DW-1:0]   rdata;
    logic            miss_inc;
    logic            unused_idata;

    assign unused_idata = ^idata;

    for (genvar i = 0; i < NSRC; i++) begin : g_bit
        if (STICKY[i]) begin : g_sticky
            logic clr;
            assign clr = wrien && (addr == ADDR_STATUS) && idata[i];
            irq_sticky_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .src   (src[i]),
                .clr   (clr),
                .flag  (status[i]),
                .miss  (miss_vec[i])
            );
        end else begin : g_live
            logic live_q, live_d;
            always_comb begin
                live_d = src[i];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    live_q <= 1'b0;
                end else begin
                    live_q <= live_d;
                end
            end
            assign status[i]   = live_q;
            assign miss_vec[i] = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_STATUS:  rdata = DW'(status);
            ADDR_ENABLE:  rdata = DW'(enable_q);
            ADDR_PENDING: rdata = DW'(status & enable_q);
            default:      rdata = DW'(miss_q);
        endcase
    end

    always_comb begin
        miss_inc = |miss_vec;
        enable_d = enable_q;
        miss_d   = miss_q;
        odata_d  = odata_q;
        irq_d    = |(status & enable_q);

        if (wrien && (addr == ADDR_ENABLE)) begin
            enable_d = idata[NSRC-1:0];
        end

        // Clear-on-read keeps an event that lands in the read cycle.
        if (rden && (addr == ADDR_MISS)) begin
            miss_d = miss_inc ? 8'd1 : 8'd0;
        end else if (miss_inc && (miss_q != MISS_MAX)) begin
            miss_d = miss_q + 8'd1;
        end

        if (rden) begin
            odata_d = rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= '0;
            miss_q   <= '0;
            odata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            miss_q   <= miss_d;
            odata_q  <= odata_d;
            irq_q    <= irq_d;
        end
    end

    assign odata = odata_q;
    assign irq   = irq_q;

endmodule

// File: doc/uart_irq_ctrl.md
# uart_irq_ctrl

Parametrised interrupt status/enable controller for the UART. It is the successor to the single 8-bit status register. Per-source status bits are either sticky (latched on a rising edge, write-1-to-clear) or live (follow the source level). A per-bit enable mask produces a registered interrupt request. A saturating counter records events missed while a sticky bit was already set. It sits between the UART receiver/transmitter status outputs and the CPU-side register bus.

## Interface
Parameters:
- NSRC, 7: number of interrupt sources; 1 ≤ NSRC ≤ DW.
- DW, 8: register bus data width.
- STICKY, 7'b000_1111: per-source mode; 1 = sticky, 0 = live. Default makes fe, crce, ore, nf sticky and txi, tbnf, dr live, in source order 0..6.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- src, input, NSRC: status sources (bit order fe, crce, ore, nf, txi, tbnf, dr), synchronous to clk.
- wrien, input, 1: register write strobe.
- rden, input, 1: register read strobe.
- addr, input, 2: register select.
- idata, input, DW: write data.
- odata, output, DW: registered read data.
- irq, output, 1: registered interrupt request, active-high.

## Operation
- Register map:
  - 0 STATUS: read; W1C on sticky bits.
  - 1 ENABLE: R/W.
  - 2 PENDING: RO, STATUS & ENABLE.
  - 3 MISS: RO, clear-on-read.
- Bits at or above NSRC read as 0. Writes to those bits are ignored.
- Edge detect: src_q holds src from the previous cycle. rise = src & ~src_q.
- Sticky bit i:
  - Sets on rise[i].
  - Clears when wrien && addr==0 && idata[i]==1.
  - When set and clear occur in the same cycle, set wins.
- Live bit i: the STATUS bit equals src_q[i]. Writes to it are ignored.
- MISS: 8-bit saturating counter (saturates at 255).
  - Increments by 1 per cycle in which any sticky bit has rise while already set, regardless of how many bits qualify.
  - rden && addr==3 loads 0, or loads 1 if an increment coincides with the read.
- ENABLE: written in full from idata[NSRC-1:0] when wrien && addr==1.
- Writes to addr 2 or 3 have no effect.
- irq is the registered value of |(STATUS & ENABLE).
- Simultaneous rden and wrien are allowed. odata returns the pre-write values.
- When rden is low, odata holds its last value.

## Timing
- Reset values: STATUS 0, src_q 0, ENABLE 0, MISS 0, odata 0, irq 0.
- Because src_q resets to 0, a source already high at the first clock after reset counts as a rising edge.
- Latency from src to irq:
  - Sticky bit: src rises before edge N → STATUS set after edge N → irq high after edge N+1.
  - Live bit: STATUS follows src_q, so STATUS is updated after edge N → irq high after edge N+1, same as the sticky case.
- Read: rden at edge N → odata valid after edge N. It reflects register values before edge N.
- W1C at edge N → STATUS bit low after edge N → irq low after edge N+1, provided no other pending bit remains.
- ENABLE write at edge N → irq reflects the new mask after edge N+1.
- Reset asserted mid-operation clears all state immediately (asynchronously). No pending event survives reset.

## Structure
- Package uart_irq_pkg contains:
  - Address constants ADDR_STATUS=0, ADDR_ENABLE=1, ADDR_PENDING=2, ADDR_MISS=3.
  - Default STICKY mask.
  - Named source indices: FE, CRCE, ORE, NF, TXI, TBNF, DR.
- One sub-module, irq_sticky_cell: a 1-bit edge detector plus sticky flag with set-wins W1C and a miss output. It is instantiated via generate for each bit where STICKY[i]=1.
- Live bits and MISS are handled in the top level.

## Test plan
- Reset, then ENABLE=0x01; pulse src[0] for 1 cycle → STATUS reads 0x01, irq=1 two edges after the pulse. Write 0x01 to STATUS → STATUS reads 0x00, irq=0 one edge later.
- Hold src[6] (dr, live) high with ENABLE=0x40 → irq=1. Drop src[6] → irq=0 two edges later. A write of 0x40 to STATUS has no effect.
- With STATUS[2]=1, pulse src[2] three times → MISS reads 3. The next read returns 0. 300 extra pulses → MISS reads 255.
- Rise on src[1] in the same cycle as a W1C of bit 1 → STATUS[1] stays 1.
- Sticky bit set with ENABLE=0 → irq stays 0 and PENDING reads 0x00. Write ENABLE=0x7F → irq=1 after edge N+1 and PENDING reads 0x01.
- Assert reset while irq=1 and MISS=5 → irq, odata, STATUS, ENABLE and MISS are all 0 before the next clk edge.
